mext_dispatch: RTL and testbench
================================

MEXT_DISPATCH -- requirements
Module: mext_dispatch

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, 255, max wait cycles for a sub-unit ack (1..65535; 0 = no timeout).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk_i  in  1  clock, all state on rising edge.
REQ-004 SHALL have port: rst_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: stb_i, cyc_i  in  1 each  core request strobe / cycle.
REQ-006 SHALL have port: funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports: op_1_i, op_2_i  in  32 each  rs1 / rs2 operands.
REQ-008 SHALL have ports: result_o  out  32; ack_o  out  1; err_o  out  1 (timeout flag, valid with ack_o).
REQ-009 SHALL have multiplier ports: mul_stb_o, mul_cyc_o out 1; mul_op_1_o, mul_op_2_o out 32; mul_op_1_is_signed_o, mul_op_2_is_signed_o, mul_result_upper_o out 1; mul_result_i in 32; mul_ack_i in 1.
REQ-010 SHALL have divider ports: div_stb_o, div_cyc_o out 1; div_op_1_o, div_op_2_o out 32; div_is_signed_o, div_result_rem_o out 1; div_result_i in 32; div_ack_i in 1.

Function
REQ-011 SHALL implement states IDLE, MUL_WAIT, DIV_WAIT, DONE; all outputs registered except ack_o/err_o.
REQ-012 SHALL set ack_o = ack_r AND stb_i, and err_o = err_r AND ack_o, so both drop combinationally when stb_i drops.
REQ-013 SHALL, in IDLE with ack_r high, load ack_r from stb_i (hold until the core drops stb_i).
REQ-014 SHALL accept a request in IDLE when stb_i, cyc_i and NOT ack_r are all high; latch funct3_i, op_1_i and op_2_i; clear err_r.
REQ-015 SHALL, on accept, take the fast path straight to DONE with the result_r values below, without strobing any sub-unit.
REQ-016 SHALL use these fast-path results: any MUL* with op_2 = 0 or op_1 = 0 -> 0; DIV/DIVU with op_2 = 0 -> 0xFFFFFFFF; REM/REMU with op_2 = 0 -> op_1; DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-017 SHALL otherwise drive mul_* or div_* operands and assert stb/cyc (both together) from the accept edge, entering MUL_WAIT or DIV_WAIT.
REQ-018 SHALL drive mul signedness as: MUL 1/1 upper 0; MULH 1/1 upper 1; MULHSU 1/0 upper 1; MULHU 0/0 upper 1.
REQ-019 SHALL drive div_is_signed_o = 1 for DIV/REM and div_result_rem_o = 1 for REM/REMU.
REQ-020 SHALL, in a WAIT state, hold operands and stb/cyc stable until the matching ack_i is sampled high.
REQ-021 SHALL, on that edge, capture the result into result_r, deassert stb/cyc, and go to DONE.
REQ-022 SHALL count WAIT cycles in a 16-bit counter cleared on accept.
REQ-023 SHALL, when ACK_TIMEOUT != 0 and the ACK_TIMEOUT-th WAIT cycle passes without ack, deassert stb/cyc, set result_r = 0 and err_r = 1, and go to DONE.
REQ-024 SHALL give ack_i priority over timeout when both occur in the same cycle.
REQ-025 SHALL, in DONE, set result_o <= result_r and ack_r <= 1, then return to IDLE.
REQ-026 SHALL have fast-path latency: ack_o high after the 2nd rising edge after accept.
REQ-027 SHALL have sub-unit latency: ack_o high 1 edge after the edge at which ack_i is sampled.
REQ-028 SHALL, if stb_i drops during WAIT, let the sub-unit transaction complete; the result is never acknowledged (ack_o gated), and ack_r clears in IDLE.
REQ-029 SHALL ignore ack_i from the unit not currently strobed.

Reset
REQ-030 SHALL, while rst_n_i is low, asynchronously force state IDLE and clear ack_r, err_r, result_o, the counter, all *_stb_o/*_cyc_o and all sub-unit operand/control outputs to 0.
REQ-031 SHALL, on reset during a WAIT state, drop sub-unit stb/cyc immediately and discard any later ack_i.

Verification
REQ-032 SHALL pass: MULHU 0xFFFFFFFF x 0xFFFFFFFF, model mul_ack_i after 3 cycles with 0xFFFFFFFE -> signed 0/0, upper 1; result_o 0xFFFFFFFE; ack_o 1 edge after mul ack.
REQ-033 SHALL pass: DIV 7 / 0 -> div_stb_o never asserts; result_o 0xFFFFFFFF; ack_o after 2nd edge; err_o 0.
REQ-034 SHALL pass: REM 0x80000000 % 0xFFFFFFFF -> fast path; result_o 0.
REQ-035 SHALL pass: ACK_TIMEOUT = 4, DIVU 100 / 7, div_ack_i held low -> div_stb_o drops after 4 wait cycles; ack_o = 1, err_o = 1, result_o = 0.
REQ-036 SHALL pass: MUL 3 x 5, stb_i dropped in MUL_WAIT, ack 15 later -> ack_o stays 0; next MUL 2 x 2 returns 4 with ack_o.
REQ-037 SHALL pass: rst_n_i pulsed low in DIV_WAIT -> div_stb_o/div_cyc_o 0 immediately; ack_o stays 0; subsequent REMU 10 % 3 returns 1.

Source files
------------

// File: rtl/mext_dispatch.sv
// RISC-V M-extension dispatcher: decodes MUL*/DIV*/REM* requests from the core,
// resolves trivial operand cases locally and forwards the rest to a multiplier or divider.
module mext_dispatch #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] op_1_i,
    input  logic [31:0] op_2_i,
    output logic [31:0] result_o,
    output logic        ack_o,
    output logic        err_o,

    output logic        mul_stb_o,
    output logic        mul_cyc_o,
    output logic [31:0] mul_op_1_o,
    output logic [31:0] mul_op_2_o,
    output logic        mul_op_1_is_signed_o,
    output logic        mul_op_2_is_signed_o,
    output logic        mul_result_upper_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_ack_i,

    output logic        div_stb_o,
    output logic        div_cyc_o,
    output logic [31:0] div_op_1_o,
    output logic [31:0] div_op_2_o,
    output logic        div_is_signed_o,
    output logic        div_result_rem_o,
    input  logic [31:0] div_result_i,
    input  logic        div_ack_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic [31:0] result_o_q, result_o_d;
    logic [15:0] cnt_q, cnt_d;

    logic        mul_stb_q, mul_stb_d;
    logic [31:0] mul_op_1_q, mul_op_1_d;
    logic [31:0] mul_op_2_q, mul_op_2_d;
    logic        mul_s1_q, mul_s1_d;
    logic        mul_s2_q, mul_s2_d;
    logic        mul_upper_q, mul_upper_d;

    logic        div_stb_q, div_stb_d;
    logic [31:0] div_op_1_q, div_op_1_d;
    logic [31:0] div_op_2_q, div_op_2_d;
    logic        div_signed_q, div_signed_d;
    logic        div_rem_q, div_rem_d;

    logic        accept;
    logic        is_mul_req;
    logic        div_ovf;
    logic        fast_hit;
    logic [31:0] fast_result;
    logic        timeout_hit;

    assign accept      = (state_q == IDLE) && stb_i && cyc_i && !ack_q;
    assign is_mul_req  = !funct3_i[2];
    // Signed overflow only exists for DIV/REM (funct3[0] clear) with INT_MIN / -1.
    assign div_ovf     = !funct3_i[0] && (op_1_i == 32'h8000_0000) && (op_2_i == 32'hFFFF_FFFF);
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

    // Operand patterns whose result is known without involving a sub-unit.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
        fast_hit    = 1'b0;
        fast_result = '0;
        if (is_mul_req) begin
            fast_hit    = (op_1_i == '0) || (op_2_i == '0);
            fast_result = '0;
        end else if (op_2_i == '0) begin
            fast_hit    = 1'b1;
            fast_result = funct3_i[1] ? op_1_i : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fast_hit    = 1'b1;
            fast_result = funct3_i[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    // State register plus all datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= '0;
            result_o_q   <= '0;
            cnt_q        <= '0;
            mul_stb_q    <= 1'b0;
            mul_op_1_q   <= '0;
            mul_op_2_q   <= '0;
            mul_s1_q     <= 1'b0;
            mul_s2_q     <= 1'b0;
            mul_upper_q  <= 1'b0;
            div_stb_q    <= 1'b0;
            div_op_1_q   <= '0;
            div_op_2_q   <= '0;
            div_signed_q <= 1'b0;
            div_rem_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            result_q     <= result_d;
            result_o_q   <= result_o_d;
            cnt_q        <= cnt_d;
            mul_stb_q    <= mul_stb_d;
            mul_op_1_q   <= mul_op_1_d;
            mul_op_2_q   <= mul_op_2_d;
            mul_s1_q     <= mul_s1_d;
            mul_s2_q     <= mul_s2_d;
            mul_upper_q  <= mul_upper_d;
            div_stb_q    <= div_stb_d;
            div_op_1_q   <= div_op_1_d;
            div_op_2_q   <= div_op_2_d;
            div_signed_q <= div_signed_d;
            div_rem_q    <= div_rem_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fast_hit)        state_d = DONE;
                    else if (is_mul_req) state_d = MUL_WAIT;
                    else                 state_d = DIV_WAIT;
                end
            end
            MUL_WAIT: if (mul_ack_i || timeout_hit) state_d = DONE;
            DIV_WAIT: if (div_ack_i || timeout_hit) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath next-values.
    always_comb begin
        ack_d        = ack_q;
        err_d        = err_q;
        result_d     = result_q;
        result_o_d   = result_o_q;
        cnt_d        = cnt_q;
        mul_stb_d    = mul_stb_q;
        mul_op_1_d   = mul_op_1_q;
        mul_op_2_d   = mul_op_2_q;
        mul_s1_d     = mul_s1_q;
        mul_s2_d     = mul_s2_q;
        mul_upper_d  = mul_upper_q;
        div_stb_d    = div_stb_q;
        div_op_1_d   = div_op_1_q;
        div_op_2_d   = div_op_2_q;
        div_signed_d = div_signed_q;
        div_rem_d    = div_rem_q;

        unique case (state_q)
            IDLE: begin
                if (ack_q) begin
                    // Previous result stays acknowledged until the core drops its strobe.
                    ack_d = stb_i;
                end else if (accept) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (fast_hit) begin
                        result_d = fast_result;
                    end else if (is_mul_req) begin
                        mul_stb_d   = 1'b1;
                        mul_op_1_d  = op_1_i;
                        mul_op_2_d  = op_2_i;
                        mul_s1_d    = (funct3_i[1:0] != 2'b11);
                        mul_s2_d    = !funct3_i[1];
                        mul_upper_d = (funct3_i[1:0] != 2'b00);
                    end else begin
                        div_stb_d    = 1'b1;
                        div_op_1_d   = op_1_i;
                        div_op_2_d   = op_2_i;
                        div_signed_d = !funct3_i[0];
                        div_rem_d    = funct3_i[1];
                    end
                end
            end
            MUL_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mul_ack_i) begin
                    result_d  = mul_result_i;
                    mul_stb_d = 1'b0;
                end else if (timeout_hit) begin
                    result_d  = '0;
                    err_d     = 1'b1;
                    mul_stb_d = 1'b0;
                end
            end
            DIV_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (div_ack_i) begin
                    result_d  = div_result_i;
                    div_stb_d = 1'b0;
                end else if (timeout_hit) begin
                    result_d  = '0;
                    err_d     = 1'b1;
                    div_stb_d = 1'b0;
                end
            end
            DONE: begin
                result_o_d = result_q;
                ack_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // stb and cyc always move together, so one register drives both.
    assign mul_stb_o            = mul_stb_q;
    assign mul_cyc_o            = mul_stb_q;
    assign mul_op_1_o           = mul_op_1_q;
    assign mul_op_2_o           = mul_op_2_q;
    assign mul_op_1_is_signed_o = mul_s1_q;
    assign mul_op_2_is_signed_o = mul_s2_q;
    assign mul_result_upper_o   = mul_upper_q;

    assign div_stb_o            = div_stb_q;
    assign div_cyc_o            = div_stb_q;
    assign div_op_1_o           = div_op_1_q;
    assign div_op_2_o           = div_op_2_q;
    assign div_is_signed_o      = div_signed_q;
    assign div_result_rem_o     = div_rem_q;

    assign result_o = result_o_q;
    assign ack_o    = ack_q && stb_i;
    assign err_o    = err_q && ack_o;

endmodule

// File: tb/tb_mext_dispatch.sv
// Self-checking bench for mext_dispatch: directed vector table, reset/abort sequences,
// and randomized requests scored against an arithmetic RISC-V M-extension model.
module tb_mext_dispatch;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stb_i, cyc_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_1_i, op_2_i;
    logic [31:0] result_o;
    logic        ack_o, err_o;
    logic        mul_stb_o, mul_cyc_o;
    logic [31:0] mul_op_1_o, mul_op_2_o;
    logic        mul_op_1_is_signed_o, mul_op_2_is_signed_o, mul_result_upper_o;
    logic [31:0] mul_result_i;
    logic        mul_ack_i;
    logic        div_stb_o, div_cyc_o;
    logic [31:0] div_op_1_o, div_op_2_o;
    logic        div_is_signed_o, div_result_rem_o;
    logic [31:0] div_result_i;
    logic        div_ack_i;

    int total = 0;
    int bad   = 0;

    mext_dispatch #(.ACK_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .stb_i(stb_i), .cyc_i(cyc_i), .funct3_i(funct3_i),
        .op_1_i(op_1_i), .op_2_i(op_2_i),
        .result_o(result_o), .ack_o(ack_o), .err_o(err_o),
        .mul_stb_o(mul_stb_o), .mul_cyc_o(mul_cyc_o),
        .mul_op_1_o(mul_op_1_o), .mul_op_2_o(mul_op_2_o),
        .mul_op_1_is_signed_o(mul_op_1_is_signed_o),
        .mul_op_2_is_signed_o(mul_op_2_is_signed_o),
        .mul_result_upper_o(mul_result_upper_o),
        .mul_result_i(mul_result_i), .mul_ack_i(mul_ack_i),
        .div_stb_o(div_stb_o), .div_cyc_o(div_cyc_o),
        .div_op_1_o(div_op_1_o), .div_op_2_o(div_op_2_o),
        .div_is_signed_o(div_is_signed_o), .div_result_rem_o(div_result_rem_o),
        .div_result_i(div_result_i), .div_ack_i(div_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        bit          drop;
        logic [31:0] res;
        bit          err;
        bit          fast;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: architectural RISC-V M-extension results.
    function automatic logic [31:0] divrem(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn, input bit rem);
        int sa, sb;
        if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
        if (sgn) begin
            sa = a;
            sb = b;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); p = 64'(sp); return p[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'({32'h0, b}); p = 64'(sp); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return divrem(a, b, 1'b1, 1'b0);
            3'd5: return divrem(a, b, 1'b0, 1'b0);
            3'd6: return divrem(a, b, 1'b1, 1'b1);
            default: return divrem(a, b, 1'b0, 1'b1);
        endcase
    endfunction

    function automatic bit model_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return (a == 0) || (b == 0);
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Expected {op1_signed, op2_signed, upper} for each multiply opcode.
    function automatic logic [2:0] exp_mul_ctl(input logic [2:0] f);
        case (f)
            3'd0:    return 3'b110;
            3'd1:    return 3'b111;
            3'd2:    return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    // Expected {is_signed, result_rem} for each divide opcode.
    function automatic logic [1:0] exp_div_ctl(input logic [2:0] f);
        case (f)
            3'd4:    return 2'b10;
            3'd5:    return 2'b00;
            3'd6:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Behavioural sub-units: compute from whatever operands/controls the DUT presents.
    function automatic logic [31:0] mul_unit(input logic [31:0] a, input logic [31:0] b,
                                             input bit s1, input bit s2, input bit up);
        logic [63:0] ea, eb, p;
        ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return up ? p[63:32] : p[31:0];
    endfunction

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input int delay, input bit drop, input logic [31:0] res,
                                input bit err, input bit fast);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.delay = delay; v.drop = drop;
        v.res = res; v.err = err; v.fast = fast;
        return v;
    endfunction

    // One complete request; delay = wait cycle in which the sub-unit acks (> TO means never).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input bit drop, input logic [31:0] exp_res,
                          input bit exp_err, input bit exp_fast);
        bit is_mul;
        bit drop_eff;
        int term;
        is_mul   = !f[2];
        drop_eff = drop && !exp_fast;
        term     = (delay > TO) ? TO : delay;
        stb_i = 1'b1; cyc_i = 1'b1; funct3_i = f; op_1_i = a; op_2_i = b;
        tick();
        check("ack_at_accept", 32'(ack_o), 32'h0);
        if (exp_fast) begin
            check("fast_no_strobe", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o}, 32'h0);
            tick();
            check("fast_no_strobe_done", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o}, 32'h0);
        end else begin
            check("unit_strobe", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o},
                  is_mul ? 32'hC : 32'h3);
            if (is_mul) begin
                check("mul_ctl", {mul_op_1_is_signed_o, mul_op_2_is_signed_o, mul_result_upper_o},
                      32'(exp_mul_ctl(f)));
                check("mul_op_1", mul_op_1_o, a);
                check("mul_op_2", mul_op_2_o, b);
            end else begin
                check("div_ctl", {div_is_signed_o, div_result_rem_o}, 32'(exp_div_ctl(f)));
                check("div_op_1", div_op_1_o, a);
                check("div_op_2", div_op_2_o, b);
            end
            for (int k = 1; k <= term; k++) begin
                if (drop && k == 1) stb_i = 1'b0;
                if (is_mul) begin
                    mul_ack_i    = (k == delay);
                    mul_result_i = (k == delay)
                        ? mul_unit(mul_op_1_o, mul_op_2_o, mul_op_1_is_signed_o,
                                   mul_op_2_is_signed_o, mul_result_upper_o)
                        : $urandom;
                    div_ack_i    = 1'b1;
                    div_result_i = $urandom;
                end else begin
                    div_ack_i    = (k == delay);
                    div_result_i = (k == delay)
                        ? divrem(div_op_1_o, div_op_2_o, div_is_signed_o, div_result_rem_o)
                        : $urandom;
                    mul_ack_i    = 1'b1;
                    mul_result_i = $urandom;
                end
                tick();
                if (k < term) begin
                    check("wait_strobe_held", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o},
                          is_mul ? 32'hC : 32'h3);
                    check("wait_op_held", is_mul ? mul_op_1_o : div_op_1_o, a);
                    check("wait_no_ack", 32'(ack_o), 32'h0);
                end
            end
            mul_ack_i = 1'b0;
            div_ack_i = 1'b0;
            check("unit_released", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o}, 32'h0);
            check("no_ack_before_done", 32'(ack_o), 32'h0);
            tick();
        end
        check("ack", 32'(ack_o), drop_eff ? 32'h0 : 32'h1);
        check("result", result_o, exp_res);
        check("err", 32'(err_o), (exp_err && !drop_eff) ? 32'h1 : 32'h0);
        stb_i = 1'b0; cyc_i = 1'b0;
        #1;
        check("ack_drops_with_stb", {ack_o, err_o}, 32'h0);
        tick();
        check("idle_no_ack", 32'(ack_o), 32'h0);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb, rres;
        int          rdel;
        bit          rfast, rerr, rdrop;

        rst_n_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; funct3_i = '0;
        op_1_i = '0; op_2_i = '0;
        mul_result_i = '0; mul_ack_i = 1'b0; div_result_i = '0; div_ack_i = 1'b0;

        vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 32'hFFFF_FFFE, 0, 0));
        vecs.push_back(mk(3'd4, 32'd7,         32'd0,         1, 0, 32'hFFFF_FFFF, 0, 1));
        vecs.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 1));
        vecs.push_back(mk(3'd5, 32'd100,       32'd7,         9, 0, 32'h0,         1, 0));
        vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 0, 1));
        vecs.push_back(mk(3'd7, 32'd10,        32'd0,         1, 0, 32'd10,        0, 1));
        vecs.push_back(mk(3'd5, 32'd9,         32'd0,         1, 0, 32'hFFFF_FFFF, 0, 1));
        vecs.push_back(mk(3'd0, 32'd0,         32'h1234,      1, 0, 32'h0,         0, 1));
        vecs.push_back(mk(3'd1, 32'h1234_5678, 32'd0,         1, 0, 32'h0,         0, 1));
        vecs.push_back(mk(3'd0, 32'd3,         32'd5,         1, 0, 32'd15,        0, 0));
        vecs.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'd2,         2, 0, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 32'd2,         4, 0, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(3'd3, 32'h8000_0000, 32'd4,         1, 0, 32'd2,         0, 0));
        vecs.push_back(mk(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 32'h8000_0000, 0, 0));
        vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2,         3, 0, 32'hFFFF_FFFD, 0, 0));
        vecs.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2,         2, 0, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(3'd0, 32'd6,         32'd7,         5, 0, 32'h0,         1, 0));
        vecs.push_back(mk(3'd0, 32'd3,         32'd5,         3, 1, 32'd15,        0, 0));
        vecs.push_back(mk(3'd0, 32'd2,         32'd2,         1, 0, 32'd4,         0, 0));

        // Reset state.
        tick(); tick();
        check("rst_result", result_o, 32'h0);
        check("rst_ack_err", {ack_o, err_o}, 32'h0);
        check("rst_strobes", {mul_stb_o, mul_cyc_o, div_stb_o, div_cyc_o}, 32'h0);
        check("rst_mul_ops", mul_op_1_o | mul_op_2_o, 32'h0);
        check("rst_div_ops", div_op_1_o | div_op_2_o, 32'h0);
        check("rst_ctl", {mul_op_1_is_signed_o, mul_op_2_is_signed_o, mul_result_upper_o,
                          div_is_signed_o, div_result_rem_o}, 32'h0);
        rst_n_i = 1'b1;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].drop,
                   vecs[i].res, vecs[i].err, vecs[i].fast);

        // Asynchronous reset in the middle of a divider transaction.
        stb_i = 1'b1; cyc_i = 1'b1; funct3_i = 3'd4; op_1_i = 32'd100; op_2_i = 32'd7;
        tick();
        check("rstwait_div_strobe", {div_stb_o, div_cyc_o}, 32'h3);
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rstwait_strobe_drop", {div_stb_o, div_cyc_o}, 32'h0);
        check("rstwait_ops_clear", div_op_1_o | div_op_2_o, 32'h0);
        check("rstwait_ack", 32'(ack_o), 32'h0);
        stb_i = 1'b0; cyc_i = 1'b0;
        div_ack_i = 1'b1; div_result_i = 32'hDEAD_BEEF;
        tick();
        rst_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rstwait_late_ack_ignored", {ack_o, div_stb_o}, 32'h0);
            check("rstwait_result_clear", result_o, 32'h0);
        end
        div_ack_i = 1'b0;
        run_op(3'd7, 32'd10, 32'd3, 2, 0, 32'd1, 0, 0);

        // Randomized requests against the arithmetic model.
        for (int n = 0; n < 200; n++) begin
            rf    = 3'($urandom_range(0, 7));
            ra    = pick_op();
            rb    = pick_op();
            rdel  = $urandom_range(1, 6);
            rdrop = ($urandom_range(0, 7) == 0);
            rfast = model_fast(rf, ra, rb);
            rerr  = !rfast && (rdel > TO);
            rres  = rerr ? 32'h0 : model(rf, ra, rb);
            run_op(rf, ra, rb, rdel, rdrop, rres, rerr, rfast);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
